// File: rtl/axi_wr_protocol_checker.sv
// axi_wr_protocol_checker
// Passive AXI write-path monitor. It snoops the AW, W and B channels and
// reports handshake timeouts, VALID drops, AW payload instability, orphan
// B responses and outstanding-depth overflow. Errors are sticky, the first
// error index is captured, and error cycles are counted with saturation.
// The checker never drives an AXI signal.
//
// Error bit map:
//   0 AW_TIMEOUT  1 B_TIMEOUT  2 AW_DROP   3 AW_UNSTABLE
//   4 W_DROP      5 B_DROP     6 B_ORPHAN  7 OUTST_OVF
module axi_wr_protocol_checker #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int MAX_WAIT  = 3,
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              chk_en,
  input  logic              clr_err,
  input  logic              awvalid,
  input  logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic              wvalid,
  input  logic              wready,
  input  logic              wlast,
  input  logic              bvalid,
  input  logic              bready,
  output logic [7:0]        err_flags,
  output logic              err_pulse,
  output logic [2:0]        first_err,
  output logic              first_valid,
  output logic [CNT_W-1:0]  err_count,
  output logic [7:0]        outst_cnt
);

  // Limits narrowed to the 8-bit width of the wait and tracking counters.
  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] MAX_OUTST_C = 8'(MAX_OUTST);

  // Bit positions inside the condition vector.
  localparam int B_AW_TIMEOUT  = 0;
  localparam int B_B_TIMEOUT   = 1;
  localparam int B_AW_DROP     = 2;
  localparam int B_AW_UNSTABLE = 3;
  localparam int B_W_DROP      = 4;
  localparam int B_B_DROP      = 5;
  localparam int B_B_ORPHAN    = 6;
  localparam int B_OUTST_OVF   = 7;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic wl_hs;
  logic aw_stall;
  logic b_stall;

  logic [7:0] wait_aw;
  logic [7:0] wait_b;
  logic [7:0] aw_cnt;
  logic [7:0] wl_cnt;

  logic              prev_awvalid;
  logic              prev_awready;
  logic [ID_W-1:0]   prev_awid;
  logic [ADDR_W-1:0] prev_awaddr;
  logic [7:0]        prev_awlen;
  logic              prev_wvalid;
  logic              prev_wready;
  logic              prev_bvalid;
  logic              prev_bready;

  logic [7:0]       cond;
  logic             err_event;
  logic [2:0]       cond_first;
  logic [CNT_W-1:0] count_base;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign b_hs     = bvalid && bready;
  assign wl_hs    = w_hs && wlast;
  assign aw_stall = awvalid && !awready;
  assign b_stall  = bvalid && !bready;

  assign outst_cnt = aw_cnt;

  // Clamped up/down counter step: simultaneous inc and dec cancel, the
  // count never rises above MAX_OUTST and never falls below zero.
  function automatic logic [7:0] step_cnt(input logic [7:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    logic [7:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      if (cnt < MAX_OUTST_C) nxt = cnt + 8'd1;
    end else if (dec && !inc) begin
      if (cnt != 8'd0) nxt = cnt - 8'd1;
    end
    return nxt;
  endfunction

  // Index of the lowest set bit; scanning downward leaves the lowest winner.
  function automatic logic [2:0] lowest_bit(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Evaluate every violation rule for the current cycle.
  always_comb begin
    cond = 8'h00;
    cond[B_AW_TIMEOUT]  = aw_stall && (wait_aw == MAX_WAIT_C);
    cond[B_B_TIMEOUT]   = b_stall && (wait_b == MAX_WAIT_C);
    cond[B_AW_DROP]     = prev_awvalid && !prev_awready && !awvalid;
    cond[B_AW_UNSTABLE] = prev_awvalid && !prev_awready && awvalid &&
                          ((awid != prev_awid) || (awaddr != prev_awaddr) ||
                           (awlen != prev_awlen));
    cond[B_W_DROP]      = prev_wvalid && !prev_wready && !wvalid;
    cond[B_B_DROP]      = prev_bvalid && !prev_bready && !bvalid;
    cond[B_B_ORPHAN]    = b_hs && ((aw_cnt == 8'd0) || (wl_cnt == 8'd0));
    cond[B_OUTST_OVF]   = aw_hs && (aw_cnt == MAX_OUTST_C) && !b_hs;
  end

  assign err_event  = chk_en && (cond != 8'h00);
  assign cond_first = lowest_bit(cond);

  // A clear in the same cycle as an event wipes the old count first.
  assign count_base = clr_err ? '0 : err_count;

  // Stall-duration counters, saturating at MAX_WAIT so timeouts re-flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wait_aw <= 8'd0;
      wait_b  <= 8'd0;
    end else begin
      if (aw_stall) begin
        if (wait_aw != MAX_WAIT_C) wait_aw <= wait_aw + 8'd1;
      end else begin
        wait_aw <= 8'd0;
      end
      if (b_stall) begin
        if (wait_b != MAX_WAIT_C) wait_b <= wait_b + 8'd1;
      end else begin
        wait_b <= 8'd0;
      end
    end
  end

  // Previous-cycle copies feeding the drop and stability rules.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_awvalid <= 1'b0;
      prev_awready <= 1'b0;
      prev_awid    <= '0;
      prev_awaddr  <= '0;
      prev_awlen   <= 8'd0;
      prev_wvalid  <= 1'b0;
      prev_wready  <= 1'b0;
      prev_bvalid  <= 1'b0;
      prev_bready  <= 1'b0;
    end else begin
      prev_awvalid <= awvalid;
      prev_awready <= awready;
      prev_awid    <= awid;
      prev_awaddr  <= awaddr;
      prev_awlen   <= awlen;
      prev_wvalid  <= wvalid;
      prev_wready  <= wready;
      prev_bvalid  <= bvalid;
      prev_bready  <= bready;
    end
  end

  // Outstanding AW and completed-write-data counts, retired by B handshakes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 8'd0;
      wl_cnt <= 8'd0;
    end else begin
      aw_cnt <= step_cnt(aw_cnt, aw_hs, b_hs);
      wl_cnt <= step_cnt(wl_cnt, wl_hs, b_hs);
    end
  end

  // Sticky flags, first-error capture, pulse and saturating event count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_flags   <= 8'h00;
      err_pulse   <= 1'b0;
      first_err   <= 3'd0;
      first_valid <= 1'b0;
      err_count   <= '0;
    end else begin
      err_flags <= (clr_err ? 8'h00 : err_flags) | (err_event ? cond : 8'h00);
      err_pulse <= err_event;
      if (err_event && (clr_err || !first_valid)) begin
        first_err   <= cond_first;
        first_valid <= 1'b1;
      end else if (clr_err) begin
        first_err   <= 3'd0;
        first_valid <= 1'b0;
      end
      if (err_event && (count_base != '1)) begin
        err_count <= count_base + 1'b1;
      end else begin
        err_count <= count_base;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_protocol_checker.sv
// tb_axi_wr_protocol_checker
// Directed bench for the AXI write-path checker, built with MAX_WAIT=3 and
// MAX_OUTST=2. Inputs change 1 time unit after each rising edge, so the
// outputs read at that point reflect the cycle that has just been sampled.
module tb_axi_wr_protocol_checker;

  logic        aclk;
  logic        aresetn;
  logic        chk_en;
  logic        clr_err;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [7:0]  err_flags;
  logic        err_pulse;
  logic [2:0]  first_err;
  logic        first_valid;
  logic [15:0] err_count;
  logic [7:0]  outst_cnt;

  int checks = 0;
  int errors = 0;

  axi_wr_protocol_checker #(
    .ID_W(4), .ADDR_W(32), .MAX_WAIT(3), .MAX_OUTST(2), .CNT_W(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .chk_en(chk_en), .clr_err(clr_err),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .err_flags(err_flags),
    .err_pulse(err_pulse), .first_err(first_err), .first_valid(first_valid),
    .err_count(err_count), .outst_cnt(outst_cnt)
  );

  // Free-running clock, period 10.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of channel activity and step past the next rising edge.
  task automatic applyStimulus(input logic aw_v, input logic aw_r,
                               input logic [31:0] addr,
                               input logic w_v, input logic w_r,
                               input logic w_l,
                               input logic b_v, input logic b_r);
    awvalid = aw_v;
    awready = aw_r;
    awaddr  = addr;
    wvalid  = w_v;
    wready  = w_r;
    wlast   = w_l;
    bvalid  = b_v;
    bready  = b_r;
    @(posedge aclk);
    #1;
  endtask

  // One idle cycle with clr_err asserted.
  task automatic clearCycle();
    clr_err = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);
    clr_err = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    aresetn = 1'b0;
    chk_en  = 1'b1;
    clr_err = 1'b0;
    awvalid = 1'b0;
    awready = 1'b0;
    awid    = 4'h0;
    awaddr  = 32'h0;
    awlen   = 8'd3;
    wvalid  = 1'b0;
    wready  = 1'b0;
    wlast   = 1'b0;
    bvalid  = 1'b0;
    bready  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("rst_flags", err_flags, 8'h00);
    checkOutput("rst_pulse", err_pulse, 1'b0);
    checkOutput("rst_fvalid", first_valid, 1'b0);
    checkOutput("rst_count", err_count, 16'd0);
    checkOutput("rst_outst", outst_cnt, 8'd0);
    aresetn = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);

    $display("[TB] legal traffic");
    repeat (3) applyStimulus(1, 0, 32'h200, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h200, 0, 0, 0, 0, 0);
    checkOutput("t1_outst1", outst_cnt, 8'd1);
    checkOutput("t1_flags_aw", err_flags, 8'h00);
    repeat (3) applyStimulus(0, 0, 32'h0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 1, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 1);
    checkOutput("t1_outst0", outst_cnt, 8'd0);
    checkOutput("t1_flags", err_flags, 8'h00);
    checkOutput("t1_count", err_count, 16'd0);

    $display("[TB] AW timeout");
    repeat (3) applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0);
    checkOutput("t2_flags_3stall", err_flags, 8'h00);
    applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0);
    checkOutput("t2_flags_4stall", err_flags, 8'h01);
    checkOutput("t2_pulse", err_pulse, 1'b1);
    checkOutput("t2_first", first_err, 3'd0);
    checkOutput("t2_fvalid", first_valid, 1'b1);
    checkOutput("t2_count1", err_count, 16'd1);
    applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0);
    checkOutput("t2_count2", err_count, 16'd2);
    applyStimulus(1, 1, 32'h300, 0, 0, 0, 0, 0);
    checkOutput("t2_pulse_hs", err_pulse, 1'b0);
    checkOutput("t2_count_hs", err_count, 16'd2);
    checkOutput("t2_outst", outst_cnt, 8'd1);
    applyStimulus(0, 0, 32'h0, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 1);
    checkOutput("t2_outst0", outst_cnt, 8'd0);
    checkOutput("t2_sticky", err_flags, 8'h01);
    clearCycle();
    checkOutput("t2_clr_flags", err_flags, 8'h00);
    checkOutput("t2_clr_count", err_count, 16'd0);
    checkOutput("t2_clr_fvalid", first_valid, 1'b0);

    $display("[TB] AW unstable and drop");
    applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h104, 0, 0, 0, 0, 0);
    checkOutput("t3_flags_unst", err_flags, 8'h08);
    checkOutput("t3_first_unst", first_err, 3'd3);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("t3_flags_drop", err_flags, 8'h0C);
    checkOutput("t3_first", first_err, 3'd3);
    checkOutput("t3_count", err_count, 16'd2);
    clearCycle();

    $display("[TB] orphan B");
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 1);
    checkOutput("t4_flags_b", err_flags, 8'h40);
    checkOutput("t4_outst_b", outst_cnt, 8'd0);
    clearCycle();
    applyStimulus(1, 1, 32'h400, 1, 1, 1, 1, 1);
    checkOutput("t4_flags_all", err_flags, 8'h40);
    checkOutput("t4_first_all", first_err, 3'd6);
    checkOutput("t4_outst_all", outst_cnt, 8'd0);
    clearCycle();

    $display("[TB] outstanding overflow");
    applyStimulus(1, 1, 32'h500, 1, 1, 1, 0, 0);
    applyStimulus(1, 1, 32'h504, 1, 1, 1, 0, 0);
    checkOutput("t5_outst2", outst_cnt, 8'd2);
    checkOutput("t5_flags_ok", err_flags, 8'h00);
    applyStimulus(1, 1, 32'h508, 0, 0, 0, 0, 0);
    checkOutput("t5_flags_ovf", err_flags, 8'h80);
    checkOutput("t5_outst_clamp", outst_cnt, 8'd2);
    clearCycle();
    applyStimulus(1, 1, 32'h50C, 0, 0, 0, 1, 1);
    checkOutput("t5_flags_awb", err_flags, 8'h00);
    checkOutput("t5_outst_awb", outst_cnt, 8'd2);
    applyStimulus(0, 0, 32'h0, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 1);
    checkOutput("t5_outst_drain", outst_cnt, 8'd0);
    checkOutput("t5_flags_drain", err_flags, 8'h00);

    $display("[TB] checking disabled");
    chk_en = 1'b0;
    applyStimulus(1, 0, 32'h600, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("dis_flags", err_flags, 8'h00);
    checkOutput("dis_count", err_count, 16'd0);
    chk_en = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("dis_reen_flags", err_flags, 8'h00);

    $display("[TB] clear with simultaneous error, then reset");
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 1);
    checkOutput("t6_flags_pre", err_flags, 8'h40);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1, 0);
    clr_err = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);
    clr_err = 1'b0;
    checkOutput("t6_flags_clr", err_flags, 8'h20);
    checkOutput("t6_first_clr", first_err, 3'd5);
    checkOutput("t6_fvalid_clr", first_valid, 1'b1);
    checkOutput("t6_count_clr", err_count, 16'd1);
    applyStimulus(1, 0, 32'h700, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h700, 0, 0, 0, 0, 0);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("t6_rst_flags", err_flags, 8'h00);
    checkOutput("t6_rst_count", err_count, 16'd0);
    checkOutput("t6_rst_fvalid", first_valid, 1'b0);
    checkOutput("t6_rst_first", first_err, 3'd0);
    checkOutput("t6_rst_pulse", err_pulse, 1'b0);
    checkOutput("t6_rst_outst", outst_cnt, 8'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("t6_rel_flags", err_flags, 8'h00);
    checkOutput("t6_rel_count", err_count, 16'd0);
    checkOutput("t6_rel_pulse", err_pulse, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
